// File: rtl/delay_width_pkg.sv
// Shared {delay, width} measurement types used by the pulse delay generator and meter.
// Also holds the per-channel measurement states of the meter.
package delay_width_pkg;

  localparam int DW_WIDTH     = 32;
  localparam int DW_NCHANNELS = 9;

  typedef struct packed {
    logic [DW_WIDTH-1:0] delay;
    logic [DW_WIDTH-1:0] width;
  } delay_width_t;

  typedef enum logic [1:0] {
    CH_IDLE  = 2'd0,
    CH_ARMED = 2'd1,
    CH_HIGH  = 2'd2,
    CH_DONE  = 2'd3
  } ch_state_t;

endpackage

// File: rtl/pulse_delay_meter_channel.sv
// One measured pin: edge detection, optional glitch filter, capture FSM and width counter.
// With PULSE_DELAY_METER_GLITCH_FILTER_EN, a pin level must be stable 2 cycles before it is accepted.
module pulse_delay_meter_channel
  import delay_width_pkg::*;
#(
  parameter int WIDTH = DW_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_t0_rise,
  input  logic             i_pin,
  input  logic [WIDTH-1:0] i_frame_cnt,
  output logic             o_done,
  output logic [WIDTH-1:0] o_delay,
  output logic [WIDTH-1:0] o_width
);

  ch_state_t        r_state;
  logic             r_pin_d;
  logic [WIDTH-1:0] r_delay;
  logic [WIDTH-1:0] r_width;
  logic             w_rise;
  logic             w_fall;
  logic [WIDTH-1:0] w_width_inc;

`ifdef PULSE_DELAY_METER_GLITCH_FILTER_EN
  logic r_pin_q;

  // r_pin_d is the accepted level; it follows the pin only after two equal samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pin_q <= 1'b0;
      r_pin_d <= 1'b0;
    end else begin
      r_pin_q <= i_pin;
      if (i_pin == r_pin_q) begin
        r_pin_d <= i_pin;
      end
    end
  end

  assign w_rise = i_pin & r_pin_q & ~r_pin_d;
  assign w_fall = ~i_pin & ~r_pin_q & r_pin_d;
`else
  // Previous synchronized level for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pin_d <= 1'b0;
    end else begin
      r_pin_d <= i_pin;
    end
  end

  assign w_rise = i_pin & ~r_pin_d;
  assign w_fall = ~i_pin & r_pin_d;
`endif

  assign w_width_inc = (r_width == {WIDTH{1'b1}}) ? r_width
                                                  : r_width + {{(WIDTH-1){1'b0}}, 1'b1};

  // A t0 edge restarts the channel; a rise on that same cycle already belongs to the new frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= CH_IDLE;
      r_delay <= {WIDTH{1'b0}};
      r_width <= {WIDTH{1'b0}};
    end else if (i_t0_rise) begin
      if (w_rise) begin
        r_state <= CH_HIGH;
        r_delay <= i_frame_cnt;
        r_width <= {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
        r_state <= CH_ARMED;
        r_delay <= {WIDTH{1'b0}};
        r_width <= {WIDTH{1'b0}};
      end
    end else begin
      case (r_state)
        CH_ARMED: begin
          if (w_rise) begin
            r_state <= CH_HIGH;
            r_delay <= i_frame_cnt;
            r_width <= {{(WIDTH-1){1'b0}}, 1'b1};
          end
        end
        CH_HIGH: begin
          if (w_fall) begin
            r_state <= CH_DONE;
          end else begin
            r_width <= w_width_inc;
          end
        end
        CH_IDLE, CH_DONE: r_state <= r_state;
        default:          r_state <= CH_IDLE;
      endcase
    end
  end

  assign o_done  = (r_state == CH_DONE);
  assign o_delay = r_delay;
  assign o_width = r_width;

endmodule

// File: rtl/pulse_delay_meter.sv
// Measures per-pin delay from t0 and pulse width, publishing one frame per t0 with valid/ack handshake.
// PULSE_DELAY_METER_GLITCH_FILTER_EN enables the per-pin glitch filter; t0 is delayed to match it.
module pulse_delay_meter
  import delay_width_pkg::*;
#(
  parameter int NDELAY_CHANNELS = DW_NCHANNELS,
  parameter int WIDTH           = DW_WIDTH
) (
  input  logic                                         clk,
  input  logic                                         reset_n,
  input  logic                                         t0,
  input  logic [NDELAY_CHANNELS-1:0]                   pins,
  output logic [NDELAY_CHANNELS-1:0][2*WIDTH-1:0]      meas_pairs,
  output logic [NDELAY_CHANNELS-1:0]                   meas_status,
  output logic                                         meas_valid,
  input  logic                                         meas_ack,
  output logic                                         overrun,
  output logic [31:0]                                  frame_count
);

  logic                                    r_t0_s1;
  logic                                    r_t0_s2;
  logic                                    r_t0_s3;
  logic [NDELAY_CHANNELS-1:0]              r_pins_s1;
  logic [NDELAY_CHANNELS-1:0]              r_pins_s2;
  logic [WIDTH-1:0]                        r_frame_cnt;
  logic                                    r_started;
  logic [NDELAY_CHANNELS-1:0][2*WIDTH-1:0] r_meas_pairs;
  logic [NDELAY_CHANNELS-1:0]              r_meas_status;
  logic                                    r_meas_valid;
  logic                                    r_overrun;
  logic [31:0]                             r_frame_count;

  logic                       w_t0_rise;
  logic [WIDTH-1:0]           w_frame_cnt;
  logic [WIDTH-1:0]           w_frame_cnt_inc;
  logic                       w_ack_accept;
  logic                       w_frame_end;
  logic                       w_publish;
  logic                       w_drop;
  logic [NDELAY_CHANNELS-1:0] w_done;
  logic [WIDTH-1:0]           w_delay [NDELAY_CHANNELS];
  logic [WIDTH-1:0]           w_width [NDELAY_CHANNELS];

  // Two-flop synchronizers for t0 and all pins, plus the t0 edge-detect tap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_t0_s1   <= 1'b0;
      r_t0_s2   <= 1'b0;
      r_t0_s3   <= 1'b0;
      r_pins_s1 <= {NDELAY_CHANNELS{1'b0}};
      r_pins_s2 <= {NDELAY_CHANNELS{1'b0}};
    end else begin
      r_t0_s1   <= t0;
      r_t0_s2   <= r_t0_s1;
      r_t0_s3   <= r_t0_s2;
      r_pins_s1 <= pins;
      r_pins_s2 <= r_pins_s1;
    end
  end

`ifdef PULSE_DELAY_METER_GLITCH_FILTER_EN
  logic r_t0_s4;

  // Extra t0 stage matching the one-cycle confirmation latency of the pin filter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_t0_s4 <= 1'b0;
    end else begin
      r_t0_s4 <= r_t0_s3;
    end
  end

  assign w_t0_rise = r_t0_s3 & ~r_t0_s4;
`else
  assign w_t0_rise = r_t0_s2 & ~r_t0_s3;
`endif

  // Counter reads 0 on the t0 detect cycle, so a rise d cycles later reports delay d.
  assign w_frame_cnt     = w_t0_rise ? {WIDTH{1'b0}} : r_frame_cnt;
  assign w_frame_cnt_inc = (w_frame_cnt == {WIDTH{1'b1}}) ? w_frame_cnt
                                                          : w_frame_cnt + {{(WIDTH-1){1'b0}}, 1'b1};

  assign w_ack_accept = meas_ack & r_meas_valid;
  assign w_frame_end  = w_t0_rise & r_started;
  assign w_publish    = w_frame_end & (~r_meas_valid | w_ack_accept);
  assign w_drop       = w_frame_end & r_meas_valid & ~meas_ack;

  for (genvar g = 0; g < NDELAY_CHANNELS; g++) begin : g_ch
    pulse_delay_meter_channel #(.WIDTH(WIDTH)) u_ch (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_t0_rise   (w_t0_rise),
      .i_pin       (r_pins_s2[g]),
      .i_frame_cnt (w_frame_cnt),
      .o_done      (w_done[g]),
      .o_delay     (w_delay[g]),
      .o_width     (w_width[g])
    );
  end

  // Frame timing, publication and the valid/ack/overrun handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_cnt   <= {WIDTH{1'b0}};
      r_started     <= 1'b0;
      r_meas_pairs  <= {(NDELAY_CHANNELS*2*WIDTH){1'b0}};
      r_meas_status <= {NDELAY_CHANNELS{1'b0}};
      r_meas_valid  <= 1'b0;
      r_overrun     <= 1'b0;
      r_frame_count <= 32'd0;
    end else begin
      r_frame_cnt <= w_frame_cnt_inc;
      r_started   <= r_started | w_t0_rise;
      if (w_publish) begin
        for (int k = 0; k < NDELAY_CHANNELS; k++) begin
          r_meas_pairs[k] <= {w_delay[k], w_width[k]};
        end
        r_meas_status <= w_done;
        r_meas_valid  <= 1'b1;
        r_frame_count <= r_frame_count + 32'd1;
      end else if (w_ack_accept) begin
        r_meas_valid <= 1'b0;
      end
      if (w_ack_accept) begin
        r_overrun <= 1'b0;
      end else if (w_drop) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign meas_pairs  = r_meas_pairs;
  assign meas_status = r_meas_status;
  assign meas_valid  = r_meas_valid;
  assign overrun     = r_overrun;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_pulse_delay_meter.sv
// Self-checking bench for pulse_delay_meter: directed frames plus random pin traces against a frame-level model.
// Expectations for the glitch frame follow PULSE_DELAY_METER_GLITCH_FILTER_EN.
module tb_pulse_delay_meter;

  localparam int N = 9;
  localparam int W = 32;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  t0;
  logic [N-1:0]          pins;
  logic [N-1:0][2*W-1:0] meas_pairs;
  logic [N-1:0]          meas_status;
  logic                  meas_valid;
  logic                  meas_ack;
  logic                  overrun;
  logic [31:0]           frame_count;

  pulse_delay_meter #(.NDELAY_CHANNELS(N), .WIDTH(W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .t0          (t0),
    .pins        (pins),
    .meas_pairs  (meas_pairs),
    .meas_status (meas_status),
    .meas_valid  (meas_valid),
    .meas_ack    (meas_ack),
    .overrun     (overrun),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  // Pin trace of the frame being driven; index 0 is the t0 rising cycle.
  logic [N-1:0] lv [0:255];
  logic [N-1:0] pl;

  int errors = 0;
  int checks = 0;

  // Frame-level model of what the consumer should see.
  bit           m_started;
  bit           m_valid;
  bit           m_overrun;
  logic [31:0]  m_fc;
  logic [N-1:0] m_status;
  logic [63:0]  m_pairs [N];
  logic [N-1:0] res_status;
  logic [63:0]  res_pairs [N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"},   64'(meas_valid),  64'(m_valid));
    chk({tag, ".overrun"}, 64'(overrun),     64'(m_overrun));
    chk({tag, ".fcount"},  64'(frame_count), 64'(m_fc));
    chk({tag, ".status"},  64'(meas_status), 64'(m_status));
    for (int k = 0; k < N; k++) begin
      chk($sformatf("%s.pair%0d", tag, k), meas_pairs[k], m_pairs[k]);
    end
  endtask

  task automatic model_reset();
    m_started = 1'b0;
    m_valid   = 1'b0;
    m_overrun = 1'b0;
    m_fc      = 32'd0;
    m_status  = '0;
    for (int k = 0; k < N; k++) m_pairs[k] = 64'd0;
  endtask

  // First low-to-high after t0 gives delay; first following fall gives width, else width runs to frame end.
  task automatic model_frame(input int len);
    for (int k = 0; k < N; k++) begin
      int rise = -1;
      int fall = -1;
      for (int i = 0; i < len; i++) begin
        logic cur;
        logic bef;
        cur = lv[i][k];
        bef = (i == 0) ? pl[k] : lv[i-1][k];
        if (rise < 0) begin
          if (cur && !bef) rise = i;
        end else if (fall < 0 && !cur && bef) begin
          fall = i;
        end
      end
      if (rise < 0) begin
        res_status[k] = 1'b0;
        res_pairs[k]  = 64'd0;
      end else if (fall >= 0) begin
        res_status[k] = 1'b1;
        res_pairs[k]  = {32'(rise), 32'(fall - rise)};
      end else begin
        res_status[k] = 1'b0;
        res_pairs[k]  = {32'(rise), 32'(len - rise)};
      end
    end
  endtask

  task automatic clear_lv(input int len);
    for (int i = 0; i < len; i++) lv[i] = '0;
  endtask

  // Random runs of at least 2 cycles, and each frame ends on a stable level.
  task automatic gen_random(input int len);
    for (int k = 0; k < N; k++) begin
      logic lvl;
      int   cnt;
      lvl = pl[k];
      cnt = int'($urandom_range(0, 12));
      for (int i = 0; i < len; i++) begin
        if (cnt == 0) begin
          lvl = ~lvl;
          cnt = int'($urandom_range(2, len / 3));
        end
        lv[i][k] = lvl;
        cnt--;
      end
      lv[len-2][k] = lv[len-3][k];
      lv[len-1][k] = lv[len-3][k];
    end
  endtask

  // Drive one frame; publication of the previous frame is checked at index 8, ack effect at index 11.
  task automatic run_frame(input int len, input int ack_idx);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      t0       = (i < 4);
      pins     = lv[i];
      meas_ack = (i == ack_idx);
      if (i == 0) begin
        if (ack_idx == 2 && m_valid) begin
          m_valid   = 1'b0;
          m_overrun = 1'b0;
        end
        if (m_started) begin
          if (!m_valid) begin
            m_valid  = 1'b1;
            m_fc     = m_fc + 32'd1;
            m_status = res_status;
            for (int k = 0; k < N; k++) m_pairs[k] = res_pairs[k];
          end else begin
            m_overrun = 1'b1;
          end
        end
        m_started = 1'b1;
      end
      if (i == 8) begin
        check_all("frame");
        if (ack_idx == 8 && m_valid) begin
          m_valid   = 1'b0;
          m_overrun = 1'b0;
        end
      end
      if (i == 11) begin
        chk("after_ack.valid",   64'(meas_valid), 64'(m_valid));
        chk("after_ack.overrun", 64'(overrun),    64'(m_overrun));
      end
    end
    model_frame(len);
    pl = lv[len-1];
  endtask

  initial begin
    int len;
    reset_n  = 1'b0;
    t0       = 1'b0;
    pins     = '0;
    meas_ack = 1'b0;
    pl       = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // Loopback-style frames: channel k at delay 10k, width 10; channel 0 rises with t0.
    clear_lv(100);
    for (int k = 0; k < N; k++)
      for (int i = 10 * k; i < 10 * k + 10; i++) lv[i][k] = 1'b1;
    run_frame(100, 8);
    clear_lv(100);
    for (int k = 0; k < N; k++)
      if (k != 3)
        for (int i = 10 * k; i < 10 * k + 10; i++) lv[i][k] = 1'b1;
    run_frame(100, 8);
    chk("loopback.status", 64'(meas_status), 64'(9'h1FF));
    for (int k = 0; k < N; k++)
      chk($sformatf("loopback.pair%0d", k), meas_pairs[k], {32'(10 * k), 32'd10});

    // Channel 0 rises at 5 and stays high past the next t0 at 100.
    clear_lv(100);
    for (int i = 5; i < 100; i++) lv[i][0] = 1'b1;
    run_frame(100, 8);
    chk("ch3_low.status", 64'(meas_status), 64'(9'h1F7));
    chk("ch3_low.pair3",  meas_pairs[3], 64'd0);
    gen_random(40);
    run_frame(40, 8);
    chk("partial.status0", 64'(meas_status[0]), 64'd0);
    chk("partial.pair0",   meas_pairs[0], {32'd5, 32'd95});

    // One-cycle glitch at 20, real pulse at 40 for 8 cycles.
    clear_lv(100);
    lv[20][0] = 1'b1;
    for (int i = 40; i < 48; i++) lv[i][0] = 1'b1;
    run_frame(100, 8);
`ifdef PULSE_DELAY_METER_GLITCH_FILTER_EN
    res_pairs[0]  = {32'd40, 32'd8};
    res_status[0] = 1'b1;
`endif
    gen_random(30);
    run_frame(30, 8);
`ifdef PULSE_DELAY_METER_GLITCH_FILTER_EN
    chk("glitch.pair0", meas_pairs[0], {32'd40, 32'd8});
`else
    chk("glitch.pair0", meas_pairs[0], {32'd20, 32'd1});
`endif

    repeat (20) begin
      len = int'($urandom_range(24, 80));
      gen_random(len);
      run_frame(len, 8);
    end

    // Ack sampled on the same cycle as a frame end: new frame is published and valid stays high.
    gen_random(32); run_frame(32, -1);
    gen_random(32); run_frame(32, 2);
    gen_random(32); run_frame(32, 8);
    gen_random(32); run_frame(32, -1);

    // Reset in the middle of a pulse clears every output at once.
    repeat (3) begin
      @(negedge clk);
      pins = '1;
    end
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_all("mid_reset");
    @(negedge clk);
    pins    = '0;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    pl = '0;

    // First frame after reset publishes nothing; then three frames without ack give overrun.
    gen_random(40); run_frame(40, 8);
    gen_random(40); run_frame(40, -1);
    gen_random(40); run_frame(40, -1);
    gen_random(40); run_frame(40, -1);
    gen_random(40); run_frame(40, 8);
    chk("overrun.fcount", 64'(frame_count), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pulse_delay_meter.md
PULSE_DELAY_METER -- requirements
Module: pulse_delay_meter

Interface
REQ-001 Parameter NDELAY_CHANNELS, default 9: number of measured pin channels.
REQ-002 Parameter WIDTH, default 32: bit width of each delay and width measurement.
REQ-003 clk  input  1  system clock; all logic in this single domain.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 t0  input  1  asynchronous frame trigger; rising edge starts a frame.
REQ-006 pins  input  NDELAY_CHANNELS  asynchronous pulse inputs to be measured.
REQ-007 meas_pairs  output  delay_width_t[NDELAY_CHANNELS]  per-channel measured {delay, width} of last published frame.
REQ-008 meas_status  output  NDELAY_CHANNELS  per channel: 1 = complete pulse captured in published frame.
REQ-009 meas_valid  output  1  published frame available; held until acknowledged.
REQ-010 meas_ack  input  1  consumer acknowledge of meas_valid.
REQ-011 overrun  output  1  sticky: a completed frame was dropped while meas_valid pending.
REQ-012 frame_count  output  32  number of frames published since reset, wraps 2^32-1 -> 0.

Function
REQ-013 t0 and each pins bit SHALL pass through a 2-FF synchronizer; edges are detected on synchronized signals, so latency cancels in measurements.
REQ-014 Frame counter SHALL load 0 on the cycle a t0 rising edge is detected and increment by 1 per clk thereafter, saturating at all-ones.
REQ-015 Per-channel FSM states: IDLE (before first t0), ARMED (wait rise), HIGH (count width), DONE.
REQ-016 Any state -> ARMED on t0 edge; ARMED -> HIGH on pin rise, delay = frame counter value at rise; HIGH -> DONE on pin fall, width = cycles from rise to fall detection.
REQ-017 Pin already high at t0 edge SHALL NOT count as rise; channel waits for a low-to-high transition.
REQ-018 Second and later pulses within one frame SHALL be ignored (DONE is absorbing until next t0).
REQ-019 Width counter SHALL saturate at all-ones; delay saturates via frame counter.
REQ-020 On each t0 edge after the first, the frame just ended SHALL be published: meas_pairs, meas_status (1 only for channels in DONE) latched, meas_valid set next cycle, frame_count incremented.
REQ-021 Channel in ARMED at frame end: status 0, pair {0,0}; in HIGH: status 0, delay captured, width = partial count.
REQ-022 Pin rise/fall coincident with t0 edge: t0 wins; the edge belongs to the new frame (rise) or is discarded (fall).
REQ-023 meas_valid SHALL clear the cycle after meas_ack is sampled high with meas_valid high; meas_ack while meas_valid low is ignored.
REQ-024 Frame end while meas_valid still high (ack not yet sampled): outputs unchanged, frame dropped, overrun set, frame_count not incremented.
REQ-025 Ack and frame end in same cycle: ack wins, new frame published, meas_valid remains high.
REQ-026 overrun SHALL clear on an accepted meas_ack.

Reset
REQ-027 reset_n low SHALL asynchronously clear synchronizers, counters, meas_pairs, meas_status, meas_valid, overrun, frame_count to 0, and all FSMs to IDLE.
REQ-028 Reset mid-frame discards the frame; first t0 after reset starts a frame without publishing.

Configuration
REQ-029 Macro PULSE_DELAY_METER_GLITCH_FILTER_EN defined: a pin level change is accepted only after being stable 2 consecutive synchronized cycles; reported delay and width unchanged for clean pulses; pulses shorter than 2 cycles ignored.
REQ-030 Macro undefined: no filter; any 1-cycle synchronized pulse is measured with width 1.

Structure
REQ-031 delay_width_t ({delay, width}, WIDTH bits each) and NDELAY_CHANNELS default SHALL live in the shared delay_width package, same type as the delay/pulse generator uses.
REQ-032 Per-channel FSM, width counter and optional glitch filter SHALL be sub-module pulse_delay_meter_channel, instantiated NDELAY_CHANNELS times by generate.

Verification
REQ-033 Loopback from generator, interval 999, channel k delay k*10 width 10 -> each frame status all 1, meas_pairs[k] = {k*10, 10}.
REQ-034 Channel 3 held low whole frame -> status[3]=0, pair {0,0}; others valid.
REQ-035 Channel 0 rises at 5, stays high past next t0 at 100 -> status[0]=0, delay 5, width 95.
REQ-036 No ack for 3 frames -> first frame held, overrun=1, frame_count=1; ack -> meas_valid low next cycle, overrun=0.
REQ-037 Reset asserted mid-pulse -> all outputs 0 within same cycle; next t0 publishes nothing.
REQ-038 1-cycle glitch at delay 20 then pulse at 40 width 8 -> filter on: {40,8}; filter off: {20,1}.
